uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one byte-level UART transmitter among `N_REQ` requesters. Each requester offers bytes over a valid/ready handshake. The arbiter grants one requester, issues a one-cycle `tx_start` with the byte, and tracks the transmitter's `tx_busy` until the frame completes. It sits between the core's byte producers (debug, console, status) and the UART TX datapath.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 16: cycles allowed after `tx_start` for `tx_busy` to rise before the byte is abandoned.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `req_valid`  input  N_REQ  requester i has a byte.
- `req_data`  input  8*N_REQ  byte of requester i, at bits [8i+7:8i].
- `req_last`  input  N_REQ  last byte of a packet; used only with `UART_ARB_LOCK_EN`.
- `req_ready`  output  N_REQ  one-cycle pulse; the byte of requester i is accepted.
- `tx_start`  output  1  one-cycle pulse to the transmitter.
- `tx_data`  output  8  byte to transmit; held stable from `tx_start` until return to IDLE.
- `tx_busy`  input  1  transmitter is shifting a frame.
- `grant_id`  output  clog2(N_REQ)  index of the current or most recent grantee.
- `busy`  output  1  arbiter is not in IDLE.
- `err`  output  1  one-cycle pulse on start timeout.

## Operation

- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer `last` is N_REQ-1, so requester 0 has top priority first.
  - Timeout counter is 0. Lock is clear.
- Handshake:
  - A transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
  - A requester holds `req_valid` and `req_data` stable until it sees `req_ready`.
  - The arbiter never retracts a grant.
- Arbitration:
  - Search order is `last+1`, `last+2`, …, wrapping modulo N_REQ.
  - The first valid requester in that order wins.
  - On a grant, `last` and `grant_id` are set to the winner.
- States:
  - IDLE: if any eligible `req_valid` is high, the arbiter registers the following, all effective next cycle, and moves to WAIT_BUSY:
    - `tx_data <= byte of winner`
    - `tx_start <= 1`
    - `req_ready[winner] <= 1`
    - `busy <= 1`
  - WAIT_BUSY:
    - `tx_start` and `req_ready` return to 0.
    - The counter increments each cycle.
    - `tx_busy`=1 moves to WAIT_DONE and clears the counter.
    - If the counter reaches START_TIMEOUT-1 with `tx_busy`=0, the arbiter pulses `err`, clears the lock and goes to IDLE. The byte is dropped, not retried.
  - WAIT_DONE: `tx_busy`=0 moves to IDLE.
- Simultaneous events: if `tx_busy` rises on the same cycle the timeout fires, `tx_busy` wins (WAIT_DONE, no `err`).
- Requester deasserting valid: a requester that drops `req_valid` before it is granted loses nothing; it is simply skipped.
- Reset mid-operation: state returns to IDLE and all outputs go to 0 on the next edge. Any frame already in progress in the transmitter completes on its own.

## Timing

- The `req_ready` pulse comes 1 cycle after `req_valid` is seen in IDLE. It coincides with `tx_start`.
- `busy` is high from the `tx_start` cycle until the cycle after `tx_busy` falls.
- Minimum gap between consecutive `tx_start` pulses: the time `tx_busy` is high + 2 cycles.
- With all N_REQ continuously valid, each requester is granted exactly once per N_REQ grants.

## Configuration

- `UART_ARB_LOCK_EN` defined (packet lock):
  - Accepting a byte with `req_last[g]`=0 sets the lock.
  - While locked, IDLE considers only requester `grant_id`; other requesters are not granted even if valid.
  - Accepting a byte with `req_last[g]`=1, or a timeout, clears the lock.
  - While locked, `last` is not advanced past the grantee.
- `UART_ARB_LOCK_EN` undefined: `req_last` is ignored and every byte is arbitrated independently.

## Test plan

- Reset then single request: `req_valid`=4'b0010, data 0x41; transmitter model holds `tx_busy` for 20 cycles.
  - Expect `tx_start`/`req_ready[1]` on cycle +1 with `tx_data`=0x41 and `grant_id`=1.
  - Expect `busy` to fall 1 cycle after `tx_busy` falls.
- Fairness: all 4 requesters continuously valid for 8 bytes.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect exactly two `req_ready` pulses per requester.
- Timeout: the transmitter model never asserts `tx_busy`.
  - Expect `err` pulse at cycle START_TIMEOUT after `tx_start`.
  - Expect return to IDLE and no retry.
  - Next valid requester is granted.
- Race: `tx_busy` rises exactly at counter = START_TIMEOUT-1.
  - Expect no `err` and normal completion.
- Lock (`UART_ARB_LOCK_EN`): requester 2 sends 3 bytes with `req_last`=0,0,1 while requester 0 is valid.
  - Expect grants 2,2,2, then 0.
  - Without the macro, expect 2,0,2,0,2.
- Reset mid-frame: assert `rst` for 1 cycle in WAIT_DONE.
  - Expect all outputs 0 next cycle.
  - Expect requester 0 to be granted first afterwards.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between requesters, the TX arbiter and the UART transmitter.
// master = arbiter side; slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic               tx_busy;

   modport master (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data
   );

   modport slave (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-level UART transmitter among N_REQ requesters.
// Optional packet lock: define UART_ARB_LOCK_EN to keep a grantee until its req_last byte.
module uart_tx_arbiter #(
   parameter int N_REQ         = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   uart_tx_arbiter_if.master        bus,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     err
);
   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(START_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   state_t             state_r;
   logic [IDW-1:0]     last_r;
   logic [IDW-1:0]     grant_id_r;
   logic [CW-1:0]      cnt_r;
   logic [N_REQ-1:0]   req_ready_r;
   logic               tx_start_r;
   logic [7:0]         tx_data_r;
   logic               busy_r;
   logic               err_r;

   logic [N_REQ-1:0]   eligible_s;
   logic               win_found_s;
   logic [IDW-1:0]     win_idx_s;
   logic [N_REQ-1:0]   win_onehot_s;
   logic [7:0]         win_data_s;
   logic [7:0]         req_bytes_s [N_REQ];

   function automatic logic [IDW-1:0] rr_slot(input logic [IDW-1:0] base, input int offs);
      return IDW'((int'(base) + offs) % N_REQ);
   endfunction

   for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
      assign req_bytes_s[g] = bus.req_data[8*g +: 8];
   end

`ifdef UART_ARB_LOCK_EN
   logic lock_r;

   // Restrict eligibility to the current grantee while a packet is open.
   always_comb begin
      eligible_s = bus.req_valid;
      if (lock_r) begin
         eligible_s = bus.req_valid & ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id_r);
      end else begin
         eligible_s = bus.req_valid;
      end
   end
`else
   logic unused_last_s;
   assign unused_last_s = ^bus.req_last;

   // Without packet lock every valid requester competes for every byte.
   always_comb begin
      eligible_s = bus.req_valid;
   end
`endif

   // Round-robin search from last+1 upward; the descending loop lets the nearest hit win.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (eligible_s[rr_slot(last_r, k)]) begin
            win_found_s = 1'b1;
            win_idx_s   = rr_slot(last_r, k);
         end else begin
            win_idx_s   = win_idx_s;
         end
      end
   end

   // Decode the winner into its ready bit and byte.
   always_comb begin
      win_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
      win_data_s   = req_bytes_s[win_idx_s];
   end

   // Grant / start-watch / frame-watch sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         last_r      <= IDW'(N_REQ - 1);
         grant_id_r  <= '0;
         cnt_r       <= '0;
         req_ready_r <= '0;
         tx_start_r  <= 1'b0;
         tx_data_r   <= 8'h00;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         lock_r      <= 1'b0;
`endif
      end else begin
         tx_start_r  <= 1'b0;
         req_ready_r <= '0;
         err_r       <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (win_found_s) begin
                  state_r     <= ST_WAIT_BUSY;
                  tx_data_r   <= win_data_s;
                  tx_start_r  <= 1'b1;
                  req_ready_r <= win_onehot_s;
                  busy_r      <= 1'b1;
                  grant_id_r  <= win_idx_s;
                  last_r      <= win_idx_s;
                  cnt_r       <= '0;
`ifdef UART_ARB_LOCK_EN
                  lock_r      <= ~bus.req_last[win_idx_s];
`endif
               end else begin
                  busy_r      <= 1'b0;
               end
            end
            ST_WAIT_BUSY: begin
               // tx_busy is checked first so a late start beats the timeout.
               if (bus.tx_busy) begin
                  state_r <= ST_WAIT_DONE;
                  cnt_r   <= '0;
               end else if (cnt_r == CW'(START_TIMEOUT - 1)) begin
                  state_r <= ST_IDLE;
                  err_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  cnt_r   <= '0;
`ifdef UART_ARB_LOCK_EN
                  lock_r  <= 1'b0;
`endif
               end else begin
                  cnt_r   <= cnt_r + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_r;
   assign bus.tx_start  = tx_start_r;
   assign bus.tx_data   = tx_data_r;
   assign grant_id      = grant_id_r;
   assign busy          = busy_r;
   assign err           = err_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random phase,
// all checked cycle by cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant_id;
   logic       busy;
   logic       err;

   uart_tx_arbiter_if #(.N_REQ(N)) arb_if ();

   uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .bus(arb_if),
      .grant_id(grant_id), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // requesters and transmitter stimulus state
   int         pend [N];
   logic [7:0] byt  [N];
   bit         drop [N];
   bit         rand_mode;
   int         tx_delay, tx_len, txw, txh;

   // reference model: one byte in flight at a time, pointer to last grantee
   int         m_last, m_lock, m_gid, m_start_edge, edge_no;
   bit         m_inflight, m_saw_busy, m_start, m_err;
   logic [N-1:0] m_ready;
   logic [7:0] m_data;

   int cyc, err_cnt, t_start, t_err;
   int glog[$];
   int ready_cnt [N];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < N; i++) begin
         arb_if.req_valid[i]       = (pend[i] > 0) && !drop[i];
         arb_if.req_data[8*i +: 8] = byt[i];
         arb_if.req_last[i]        = (pend[i] == 1);
      end
   endtask

   task automatic model_edge();
      edge_no++;
      m_start = 1'b0;
      m_ready = '0;
      m_err   = 1'b0;
      if (rst) begin
         m_last = N - 1; m_lock = -1; m_gid = 0; m_data = 8'h00;
         m_inflight = 1'b0; m_saw_busy = 1'b0;
      end else if (!m_inflight) begin
         int w = -1;
         for (int k = N; k >= 1; k--) begin
            int c = (m_last + k) % N;
            if (arb_if.req_valid[c] && (m_lock < 0 || m_lock == c)) w = c;
         end
         if (w >= 0) begin
            m_start = 1'b1;
            m_ready[w] = 1'b1;
            m_data = arb_if.req_data[8*w +: 8];
            m_gid = w;
            m_last = w;
            m_inflight = 1'b1;
            m_saw_busy = 1'b0;
            m_start_edge = edge_no;
`ifdef UART_ARB_LOCK_EN
            m_lock = arb_if.req_last[w] ? -1 : w;
`endif
         end
      end else if (!m_saw_busy) begin
         if (arb_if.tx_busy) m_saw_busy = 1'b1;
         else if (edge_no - m_start_edge == TO) begin
            m_err = 1'b1; m_inflight = 1'b0; m_lock = -1;
         end
      end else if (!arb_if.tx_busy) begin
         m_inflight = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_eq("tx_start", arb_if.tx_start, m_start);
      check_eq("req_ready", arb_if.req_ready, m_ready);
      check_eq("busy", busy, m_inflight);
      check_eq("err", err, m_err);
      check_eq("grant_id", grant_id, m_gid);
      check_eq("tx_data", arb_if.tx_data, m_data);
      if (arb_if.tx_start) begin glog.push_back(int'(grant_id)); t_start = cyc; end
      if (err) begin err_cnt++; t_err = cyc; end
      for (int i = 0; i < N; i++) begin
         if (arb_if.req_ready[i]) ready_cnt[i]++;
         if (m_ready[i]) begin pend[i]--; byt[i] = 8'($urandom); end
         if (rand_mode) begin
            if (pend[i] == 0 && $urandom_range(0, 5) == 0) pend[i] = $urandom_range(1, 3);
            drop[i] = ($urandom_range(0, 7) == 0);
         end else drop[i] = 1'b0;
      end
      if (arb_if.tx_busy) begin
         if (txh <= 1) arb_if.tx_busy = 1'b0; else txh--;
      end
      if (m_err) txw = -1;
      if (m_start) begin
         if (rand_mode) begin
            int r = $urandom_range(0, 9);
            tx_delay = (r == 0) ? TO + 3 : (r == 1) ? TO - 1 : $urandom_range(0, 3);
            tx_len   = $urandom_range(1, 6);
         end
         txw = tx_delay;
      end
      if (txw == 0) begin arb_if.tx_busy = 1'b1; txh = tx_len; txw = -1; end
      else if (txw > 0) txw--;
      apply_inputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain(input string tag, input int budget);
      bit quiet = 1'b0;
      for (int i = 0; i < budget && !quiet; i++) begin
         step();
         quiet = !m_inflight && !arb_if.tx_busy && (txw < 0);
         for (int j = 0; j < N; j++) if (pend[j] != 0) quiet = 1'b0;
      end
      check_eq(tag, quiet, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_log(input string tag, input int exp [5], input int n);
      check_eq({tag, "_len"}, glog.size(), n);
      for (int i = 0; i < n; i++)
         check_eq(tag, (i < glog.size()) ? glog[i] : -1, exp[i]);
   endtask

   initial begin
      int exp_log [5];
      rst = 1'b1;
      rand_mode = 1'b0; tx_delay = 0; tx_len = 3; txw = -1; txh = 0;
      cyc = 0; edge_no = 0; err_cnt = 0; t_start = 0; t_err = 0;
      for (int i = 0; i < N; i++) begin pend[i] = 0; byt[i] = 8'h00; drop[i] = 1'b0; ready_cnt[i] = 0; end
      arb_if.tx_busy = 1'b0;
      apply_inputs();
      step();
      step();
      check_eq("reset_outputs", {busy, err, arb_if.tx_start, arb_if.req_ready, grant_id, arb_if.tx_data}, 17'd0);
      rst = 1'b0;

      // single request from requester 1, 20-cycle frame
      tx_len = 20; pend[1] = 1; byt[1] = 8'h41; apply_inputs();
      step();
      check_eq("single_ready", arb_if.req_ready, 4'b0010);
      check_eq("single_data", arb_if.tx_data, 8'h41);
      check_eq("single_gid", grant_id, 2'd1);
      drain("single_drain", 60);

      // fairness: everyone valid for two bytes
      do_reset();
      glog.delete(); tx_len = 2;
      for (int i = 0; i < N; i++) begin pend[i] = 2; byt[i] = 8'($urandom); ready_cnt[i] = 0; end
      apply_inputs();
      drain("fair_drain", 200);
      check_eq("fair_len", glog.size(), 8);
      for (int i = 0; i < 8; i++) check_eq("fair_order", (i < glog.size()) ? glog[i] : -1, i % N);
      for (int i = 0; i < N; i++) check_eq("fair_count", ready_cnt[i], 2);

      // timeout: transmitter never starts; each byte dropped, next requester served
      glog.delete(); err_cnt = 0; tx_delay = -1; pend[2] = 1; pend[3] = 1; apply_inputs();
      drain("timeout_drain", 100);
      check_eq("timeout_errs", err_cnt, 2);
      check_eq("timeout_latency", t_err - t_start, TO);
      exp_log = '{2, 3, 0, 0, 0};
      check_log("timeout_order", exp_log, 2);

      // race: tx_busy rises exactly as the counter hits its limit
      glog.delete(); err_cnt = 0; tx_delay = TO - 1; tx_len = 4; pend[0] = 1; apply_inputs();
      drain("race_drain", 100);
      check_eq("race_errs", err_cnt, 0);

      // park the pointer on requester 1, then the packet test
      tx_delay = 0; tx_len = 2; pend[1] = 1; apply_inputs();
      drain("park_drain", 50);
      glog.delete(); pend[2] = 3; pend[0] = 2; apply_inputs();
      drain("lock_drain", 200);
`ifdef UART_ARB_LOCK_EN
      exp_log = '{2, 2, 2, 0, 0};
`else
      exp_log = '{2, 0, 2, 0, 2};
`endif
      check_log("lock_order", exp_log, 5);

      // reset while the frame is in progress
      tx_len = 20; pend[1] = 1; apply_inputs();
      run(6);
      check_eq("mid_busy", busy, 1'b1);
      do_reset();
      check_eq("midrst_outputs", {busy, err, arb_if.tx_start, arb_if.req_ready, grant_id, arb_if.tx_data}, 17'd0);
      glog.delete(); pend[0] = 1; pend[2] = 1; apply_inputs();
      drain("midrst_drain", 200);
      exp_log = '{0, 2, 0, 0, 0};
      check_log("midrst_order", exp_log, 2);

      // random traffic with random transmitter latency, timeouts and races
      rand_mode = 1'b1;
      run(1500);
      rand_mode = 1'b0;
      drain("random_drain", 600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
